hamming_tx_serializer: RTL
==========================

Name: hamming_tx_serializer

Overview:
Transmit-side partner of the Hamming(7,4) decoder: accepts 4-bit nibbles over a valid/ready handshake, encodes each into a 7-bit Hamming codeword, and serializes it onto a single line as a framed bit stream.
- Codeword layout, bit 6..0: p1, p2, x3, p4, x2, x1, x0, i.e. Hamming positions 1..7.
- Optional single-bit error injection lets the link and the downstream decoder's correction be exercised end to end.

Parameters:
CLKS_PER_BIT, 4, clock cycles per serial bit (legal range 1..255).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
data_in  input  4  nibble {x3,x2,x1,x0}
data_valid  input  1  data_in (and err_pos) valid
data_ready  output  1  block can accept a nibble this cycle
err_pos  input  3  0 = no error; 1..7 = invert Hamming position k, i.e. codeword bit 7-k, on the line only
tx_out  output  1  serial line, idles high
tx_busy  output  1  frame in progress
code_out  output  7  registered clean codeword of the last accepted nibble
code_valid  output  1  one-cycle pulse when code_out updates

Behaviour:
- Encoding:
  - p1 = x3^x2^x0; p2 = x3^x1^x0; p4 = x2^x1^x0.
  - codeword = {p1,p2,x3,p4,x2,x1,x0}.
  - Line word = codeword XOR mask, where mask has a single 1 at bit 7-err_pos, or is all zero when err_pos = 0.
- Reset (rst high at a clock edge): state IDLE, tx_out = 1, tx_busy = 0, code_out = 0, code_valid = 0, counters = 0.
  - data_ready = (state == IDLE) && !rst, so it is 0 while rst is high.
  - rst mid-frame aborts the frame; tx_out returns high on the next edge.
- Handshake:
  - Transfer occurs at an edge where data_valid && data_ready.
  - data_in and err_pos are sampled only at that edge.
  - data_valid while not ready is ignored; the block does not store it.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_out = 1, tx_busy = 0. On transfer: latch the line word, load code_out, pulse code_valid for the next cycle, go to START.
  - START: tx_out = 0 for CLKS_PER_BIT cycles, then go to DATA with bit index = 6.
  - DATA: tx_out = line_word[index] for CLKS_PER_BIT cycles per bit, MSB first (bit 6 down to bit 0). After bit 0's last cycle, go to STOP.
  - STOP: tx_out = 1 for CLKS_PER_BIT cycles, then go to IDLE.
  - tx_busy = 1 in START, DATA and STOP.
- Timing:
  - Frame length is 9*CLKS_PER_BIT cycles from the first START cycle.
  - The first START cycle is the cycle after the transfer edge.
  - data_ready returns to 1 in the first IDLE cycle after STOP. Back-to-back frames are therefore separated by exactly one idle-high cycle.
- Counters:
  - Bit-period counter is 8 bits and counts 0..CLKS_PER_BIT-1, wrapping to 0 on each bit boundary.
  - Bit index is 3 bits and is decremented only at bit boundaries in DATA.
- All outputs are registered except data_ready.
- No glitches on tx_out: tx_out changes only at clock edges.

Decomposition:
- Shared package hamming_pkg:
  - Constants for the bit positions of P1 = 6, P2 = 5, X3 = 4, P4 = 3, X2 = 2, X1 = 1, X0 = 0.
  - Function or localparams for the parity equations.
  - State encoding for IDLE, START, DATA, STOP.
  - The decoder re-uses the parity constants from this package.
- One natural sub-module: hamming_encoder, a combinational nibble-to-codeword block plus err_pos mask. It is instantiated here and reusable by the bench's reference model.

Test Plan:
- Reset then idle: rst high 2 cycles, then low -> tx_out = 1, tx_busy = 0, code_valid = 0; data_ready = 0 during rst and 1 after.
- Single frame, CLKS_PER_BIT = 4, data_in = 4'b1011, err_pos = 0 -> code_out = 7'b0110011 with code_valid pulsed 1 cycle; line samples 0 | 0,1,1,0,0,1,1 | 1, each held 4 cycles; 36 busy cycles.
- Encoding sweep: 4'b0000 -> 7'b0000000; 4'b1111 -> 7'b1111111; 4'b0001 -> 7'b1101001. All 16 nibbles are fed through the Hamming decoder model and must return the input nibble.
- Error injection: data_in = 4'b1011, err_pos = 3 -> code_out = 7'b0110011, but the line carries 7'b0100011; the decoder model must correct it back to 4'b1011.
- Back-to-back frames with data_valid held high: nibbles 4'b0001 then 4'b1111 -> exactly one idle-high cycle between frames; second transfer occurs in that cycle; data_ready is low throughout each frame.
- Reset mid-frame: assert rst during DATA bit 3 -> next edge gives tx_out = 1 and tx_busy = 0; first post-reset transfer produces a complete, correct frame.

Source files
------------

// File: rtl/hamming_pkg.sv
// ============================================================================
// Module      : hamming_pkg
// Description : Shared Hamming(7,4) bit positions, parity helper and TX states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hamming_pkg;

    // Codeword bit indices (bit 6 = Hamming position 1 ... bit 0 = position 7)
    localparam int P1_POS = 6;
    localparam int P2_POS = 5;
    localparam int X3_POS = 4;
    localparam int P4_POS = 3;
    localparam int X2_POS = 2;
    localparam int X1_POS = 1;
    localparam int X0_POS = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    function automatic logic [6:0] hamming_encode(input logic [3:0] i_nib);
        logic [6:0] w_c;
        w_c         = '0;
        w_c[X3_POS] = i_nib[3];
        w_c[X2_POS] = i_nib[2];
        w_c[X1_POS] = i_nib[1];
        w_c[X0_POS] = i_nib[0];
        w_c[P1_POS] = i_nib[3] ^ i_nib[2] ^ i_nib[0];
        w_c[P2_POS] = i_nib[3] ^ i_nib[1] ^ i_nib[0];
        w_c[P4_POS] = i_nib[2] ^ i_nib[1] ^ i_nib[0];
        return w_c;
    endfunction

endpackage

`default_nettype wire

// File: rtl/hamming_encoder.sv
// ============================================================================
// Module      : hamming_encoder
// Description : Combinational nibble-to-codeword encoder with error-injection mask.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_encoder
    import hamming_pkg::*;
(
    input  logic [3:0] i_data,
    input  logic [2:0] i_err_pos,
    output logic [6:0] o_code,
    output logic [6:0] o_line
);

    logic [6:0] w_mask;

    // Hamming position k lives at codeword bit 7-k; position 0 means no error
    assign w_mask = (i_err_pos == 3'd0) ? 7'd0
                                        : 7'(7'd1 << (3'd7 - i_err_pos));
    assign o_code = hamming_encode(i_data);
    assign o_line = o_code ^ w_mask;

endmodule

`default_nettype wire

// File: rtl/hamming_tx_serializer.sv
// ============================================================================
// Module      : hamming_tx_serializer
// Description : Hamming(7,4) encoder feeding a start/7-data/stop serial framer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hamming_tx_serializer
    import hamming_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    input  logic [2:0] err_pos,
    output logic       tx_out,
    output logic       tx_busy,
    output logic [6:0] code_out,
    output logic       code_valid
);

    localparam logic [7:0] c_CNT_MAX = 8'(CLKS_PER_BIT - 1);

    tx_state_t  r_state;
    logic [7:0] r_cnt;
    logic [2:0] r_idx;
    logic [6:0] r_word;
    logic       r_tx;
    logic       r_busy;
    logic [6:0] r_code;
    logic       r_code_valid;

    logic [6:0] w_code;
    logic [6:0] w_line;
    logic [7:0] w_word_ext;
    logic       w_xfer;
    logic       w_bit_end;

    hamming_encoder u_enc (
        .i_data    (data_in),
        .i_err_pos (err_pos),
        .o_code    (w_code),
        .o_line    (w_line)
    );

    assign data_ready = (r_state == ST_IDLE) && !rst;
    assign w_xfer     = data_valid && data_ready;
    assign w_bit_end  = (r_cnt == c_CNT_MAX);
    // Zero-extended so any 3-bit index stays inside the vector
    assign w_word_ext = {1'b0, r_word};

    // tx_out is loaded one state ahead so each state's line level is present
    // from its very first cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 8'd0;
            r_idx        <= 3'd0;
            r_word       <= 7'd0;
            r_tx         <= 1'b1;
            r_busy       <= 1'b0;
            r_code       <= 7'd0;
            r_code_valid <= 1'b0;
        end else begin
            r_code_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_xfer) begin
                        r_word       <= w_line;
                        r_code       <= w_code;
                        r_code_valid <= 1'b1;
                        r_cnt        <= 8'd0;
                        r_tx         <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= 8'd0;
                        r_idx   <= 3'd6;
                        r_tx    <= r_word[6];
                        r_state <= ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= 8'd0;
                        if (r_idx == 3'd0) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_idx <= r_idx - 3'd1;
                            r_tx  <= w_word_ext[r_idx - 3'd1];
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= 8'd0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign tx_out     = r_tx;
    assign tx_busy    = r_busy;
    assign code_out   = r_code;
    assign code_valid = r_code_valid;

endmodule

`default_nettype wire
